// File: rtl/simd_mac_acc.sv
// LANES-wide signed multiply-accumulate with per-lane bias preload, framed accumulation,
// pipelined products, optional saturation and sticky per-lane overflow reporting.
module simd_mac_acc #(
    parameter int unsigned LANES       = 2,
    parameter int unsigned DATA_W      = 9,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned MULT_STAGES = 2,
    parameter int unsigned SATURATE    = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic                     in_start,
    input  logic                     in_last,
    input  logic [LANES*DATA_W-1:0]  x,
    input  logic [LANES*DATA_W-1:0]  y,
    input  logic [LANES*ACC_W-1:0]   z,
    output logic                     out_valid,
    output logic [LANES*ACC_W-1:0]   out_p,
    output logic [LANES-1:0]         out_ovf
);

    localparam int unsigned PW   = ACC_W + 1;
    localparam int unsigned LAST = MULT_STAGES - 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [DATA_W-1:0] x_l    [LANES];
    logic signed [DATA_W-1:0] y_l    [LANES];
    logic signed [PW-1:0]     prod_c [LANES];

    logic                     vld_q   [MULT_STAGES];
    logic                     start_q [MULT_STAGES];
    logic                     last_q  [MULT_STAGES];
    logic signed [PW-1:0]     prod_q  [MULT_STAGES][LANES];
    logic signed [ACC_W-1:0]  z_q     [MULT_STAGES][LANES];

    logic signed [ACC_W-1:0]  acc_q   [LANES];
    logic        [LANES-1:0]  sticky_q;
    logic                     fin_q;

    logic signed [PW-1:0]     base_c  [LANES];
    logic signed [PW-1:0]     sum_c   [LANES];
    logic        [ACC_W-1:0]  acc_nxt [LANES];
    logic        [LANES-1:0]  ovf_c;

    // Full-precision lane products, sign-extended to the accumulate width
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            x_l[i]    = x[i*DATA_W +: DATA_W];
            y_l[i]    = y[i*DATA_W +: DATA_W];
            prod_c[i] = PW'(x_l[i]) * PW'(y_l[i]);
        end
    end

    // Product pipeline; framing bits are qualified by in_valid on entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned s = 0; s < MULT_STAGES; s++) begin
                vld_q[s]   <= 1'b0;
                start_q[s] <= 1'b0;
                last_q[s]  <= 1'b0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    prod_q[s][i] <= '0;
                    z_q[s][i]    <= '0;
                end
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < MULT_STAGES; s++) begin
                vld_q[s]   <= 1'b0;
                start_q[s] <= 1'b0;
                last_q[s]  <= 1'b0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    prod_q[s][i] <= '0;
                    z_q[s][i]    <= '0;
                end
            end
        end else begin
            vld_q[0]   <= in_valid;
            start_q[0] <= in_valid & in_start;
            last_q[0]  <= in_valid & in_last;
            for (int unsigned i = 0; i < LANES; i++) begin
                prod_q[0][i] <= prod_c[i];
                z_q[0][i]    <= z[i*ACC_W +: ACC_W];
            end
            for (int unsigned s = 1; s < MULT_STAGES; s++) begin
                vld_q[s]   <= vld_q[s-1];
                start_q[s] <= start_q[s-1];
                last_q[s]  <= last_q[s-1];
                for (int unsigned i = 0; i < LANES; i++) begin
                    prod_q[s][i] <= prod_q[s-1][i];
                    z_q[s][i]    <= z_q[s-1][i];
                end
            end
        end
    end

    // One guard bit above ACC_W: overflow shows as the top two sum bits disagreeing
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            base_c[i]  = start_q[LAST] ? PW'(z_q[LAST][i]) : PW'(acc_q[i]);
            sum_c[i]   = base_c[i] + prod_q[LAST][i];
            ovf_c[i]   = sum_c[i][ACC_W] ^ sum_c[i][ACC_W-1];
            acc_nxt[i] = sum_c[i][ACC_W-1:0];
            if (ovf_c[i] && (SATURATE != 0)) begin
                acc_nxt[i] = sum_c[i][ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    // Accumulators and sticky flags hold across bubbles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < LANES; i++) acc_q[i] <= '0;
            sticky_q <= '0;
            fin_q    <= 1'b0;
        end else if (flush) begin
            for (int unsigned i = 0; i < LANES; i++) acc_q[i] <= '0;
            sticky_q <= '0;
            fin_q    <= 1'b0;
        end else begin
            fin_q <= vld_q[LAST] & last_q[LAST];
            if (vld_q[LAST]) begin
                for (int unsigned i = 0; i < LANES; i++) acc_q[i] <= acc_nxt[i];
                sticky_q <= start_q[LAST] ? ovf_c : (sticky_q | ovf_c);
            end
        end
    end

    // Result registers hold the last emitted frame between pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_ovf   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_ovf   <= '0;
        end else begin
            out_valid <= fin_q;
            if (fin_q) begin
                for (int unsigned i = 0; i < LANES; i++) out_p[i*ACC_W +: ACC_W] <= acc_q[i];
                out_ovf <= sticky_q;
            end
        end
    end

endmodule

// File: tb/tb_simd_mac_acc.sv
// Scoreboard bench for simd_mac_acc: three configurations driven with shared lane stimulus,
// a beat-level reference model pushes expected frames, a negedge monitor pops and compares.
module tb_simd_mac_acc;

    typedef struct {
        logic [95:0] p;
        logic [3:0]  ovf;
        int          cyc;
    } exp_t;

    localparam longint ACC_MAXV = 64'sd8388607;
    localparam longint ACC_MINV = -64'sd8388608;
    localparam longint RANGE    = 64'sd16777216;

    logic clk = 1'b0;
    logic rstn, flush, in_valid, in_start, in_last;
    logic [17:0] x0, y0;
    logic [47:0] z0;
    logic [35:0] x4, y4;
    logic [95:0] z4;
    logic        ov0, ov1, ov2;
    logic [47:0] p0;
    logic [95:0] p1, p2;
    logic [1:0]  f0;
    logic [3:0]  f1, f2;

    logic        ovv [3];
    logic [95:0] op  [3];
    logic [3:0]  of  [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ms    [3] = '{2, 1, 3};
    int lanes [3] = '{2, 4, 4};
    int sat   [3] = '{1, 0, 1};

    longint m_acc [3][4];
    bit     m_st  [3][4];
    exp_t   q     [3][$];
    int     ax [4], ay [4], az [4];

    simd_mac_acc #(.LANES(2), .DATA_W(9), .ACC_W(24), .MULT_STAGES(2), .SATURATE(1)) d0 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_start(in_start),
        .in_last(in_last), .x(x0), .y(y0), .z(z0), .out_valid(ov0), .out_p(p0), .out_ovf(f0));

    simd_mac_acc #(.LANES(4), .DATA_W(9), .ACC_W(24), .MULT_STAGES(1), .SATURATE(0)) d1 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_start(in_start),
        .in_last(in_last), .x(x4), .y(y4), .z(z4), .out_valid(ov1), .out_p(p1), .out_ovf(f1));

    simd_mac_acc #(.LANES(4), .DATA_W(9), .ACC_W(24), .MULT_STAGES(3), .SATURATE(1)) d2 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_start(in_start),
        .in_last(in_last), .x(x4), .y(y4), .z(z4), .out_valid(ov2), .out_p(p2), .out_ovf(f2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        ovv[0] = ov0;  op[0] = 96'(p0); of[0] = 4'(f0);
        ovv[1] = ov1;  op[1] = p1;      of[1] = f1;
        ovv[2] = ov2;  op[2] = p2;      of[2] = f2;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[k][i] = 0;
                m_st[k][i]  = 1'b0;
            end
            q[k].delete();
        end
    endtask

    task automatic model_beat(input bit v, input bit s, input bit l);
        exp_t   e;
        longint sm;
        bit     ov;
        if (!v) return;
        for (int k = 0; k < 3; k++) begin
            e.p = '0;
            e.ovf = '0;
            e.cyc = cyc;
            for (int i = 0; i < lanes[k]; i++) begin
                sm = longint'(ax[i]) * longint'(ay[i]);
                sm = s ? sm + longint'(az[i]) : sm + m_acc[k][i];
                ov = (sm > ACC_MAXV) || (sm < ACC_MINV);
                if (ov && sat[k] != 0) sm = (sm > ACC_MAXV) ? ACC_MAXV : ACC_MINV;
                else if (ov)           sm = (sm > ACC_MAXV) ? sm - RANGE : sm + RANGE;
                m_acc[k][i] = sm;
                m_st[k][i]  = s ? ov : (m_st[k][i] | ov);
                e.p[i*24 +: 24] = 24'(sm);
                e.ovf[i] = m_st[k][i];
            end
            if (l) q[k].push_back(e);
        end
    endtask

    // One clock of stimulus; the model sees exactly what the DUTs will sample
    task automatic beat(input bit v, input bit s, input bit l, input bit fl);
        @(posedge clk);
        #1;
        in_valid = v;
        in_start = s;
        in_last  = l;
        flush    = fl;
        for (int i = 0; i < 4; i++) begin
            x4[i*9 +: 9]   = 9'(ax[i]);
            y4[i*9 +: 9]   = 9'(ay[i]);
            z4[i*24 +: 24] = 24'(az[i]);
            if (i < 2) begin
                x0[i*9 +: 9]   = 9'(ax[i]);
                y0[i*9 +: 9]   = 9'(ay[i]);
                z0[i*24 +: 24] = 24'(az[i]);
            end
        end
        if (fl) model_clear();
        else    model_beat(v, s, l);
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_all(input int xv, input int yv, input int zv);
        for (int i = 0; i < 4; i++) begin
            ax[i] = xv; ay[i] = yv; az[i] = zv;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_d%0d_valid", tag, k), 96'(ovv[k]), 96'(0));
            check($sformatf("%s_d%0d_p", tag, k), op[k], 96'(0));
            check($sformatf("%s_d%0d_ovf", tag, k), 96'(of[k]), 96'(0));
        end
    endtask

    // Driven after edge c, sampled at edge c+1, emitted MULT_STAGES+1 edges later
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rstn && ovv[k]) begin
                if (q[k].size() == 0) begin
                    check($sformatf("d%0d_spurious_valid", k), 96'(ovv[k]), 96'(0));
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    check($sformatf("d%0d_p", k), op[k], e.p);
                    check($sformatf("d%0d_ovf", k), 96'(of[k]), 96'(e.ovf));
                    check($sformatf("d%0d_latency", k), 96'(cyc - e.cyc), 96'(ms[k] + 2));
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
        x0 = '0; y0 = '0; z0 = '0; x4 = '0; y4 = '0; z4 = '0;
        set_all(0, 0, 0);
        model_clear();
        #12;
        chk_zero("reset");
        @(negedge clk) rstn = 1'b1;
        idle(3);

        // Single-beat frame
        ax = '{3, -5, 7, -2}; ay = '{7, 4, -3, 100}; az = '{100, -1, 50, 0};
        beat(1, 1, 1, 0);
        idle(6);

        // Four beats with a bubble, then a back-to-back single-term frame
        set_all(2, 3, 10);
        beat(1, 1, 0, 0);
        beat(1, 0, 0, 0);
        beat(0, 0, 0, 0);
        beat(1, 0, 0, 0);
        beat(1, 0, 1, 0);
        set_all(1, 1, 0);
        beat(1, 1, 1, 0);
        idle(6);

        // Positive and negative overflow
        ax = '{10, -10, 10, -10}; ay = '{10, 10, 10, 10};
        az = '{8388600, -8388600, 8388600, -8388600};
        beat(1, 1, 1, 0);
        idle(6);

        // Largest-magnitude product
        set_all(-256, -256, 0);
        beat(1, 1, 1, 0);
        idle(6);

        // Sticky overflow across a frame, then a clean frame
        set_all(10, 10, 8388600);
        beat(1, 1, 0, 0);
        set_all(-10, 10, 0);
        beat(1, 0, 1, 0);
        set_all(1, 1, 0);
        beat(1, 1, 1, 0);
        idle(6);

        // Flush with a completed frame still in flight and a valid beat in the same cycle
        set_all(3, 2, 7);
        beat(1, 1, 0, 0);
        beat(1, 0, 0, 0);
        beat(1, 0, 1, 0);
        beat(1, 1, 1, 1);
        beat(0, 0, 0, 0);
        #2;
        chk_zero("flush");
        set_all(1, 1, 5);
        beat(1, 1, 1, 0);
        idle(8);

        // Random framing, bubbles, mid-frame restarts and occasional large biases
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++) begin
                ax[i] = int'($urandom_range(0, 511)) - 256;
                ay[i] = int'($urandom_range(0, 511)) - 256;
                az[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16777215)) - 8388608
                                                    : int'($urandom_range(0, 2000)) - 1000;
            end
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, 1'b0);
        end
        idle(8);

        // Asynchronous reset mid-frame with a completed frame in flight
        set_all(4, 5, 9);
        beat(1, 1, 0, 0);
        beat(1, 0, 1, 0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        model_clear();
        #1;
        chk_zero("rst_mid");
        in_valid = 1'b0;
        @(negedge clk) rstn = 1'b1;
        idle(8);
        set_all(2, 2, 0);
        beat(1, 0, 1, 0);
        idle(6);

        for (int n = 0; n < 50 && (q[0].size() + q[1].size() + q[2].size()) != 0; n++)
            @(posedge clk);
        check("drain", 96'(q[0].size() + q[1].size() + q[2].size()), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
